// File: rtl/gpio_pixel_packer_if.sv
// Stream-side bundle for gpio_pixel_packer.
//   gpio/gpio_en   : processor GPIO word and per-channel write enables
//   start/frame_len: frame arm pulse and pixel count
//   pix_*          : valid/ready pixel stream toward the frame sink
//   busy/frame_done/overflow: status
// The master modport is the side that drives GPIO, control and pix_ready.
// The slave modport is the packer itself.
interface gpio_pixel_packer_if #(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned BYTE_W   = 8,
    parameter int unsigned CNT_W    = 16
);
    logic [WORD_W-1:0]          gpio;
    logic [CHANNELS-1:0]        gpio_en;
    logic                       start;
    logic [CNT_W-1:0]           frame_len;
    logic                       pix_valid;
    logic                       pix_ready;
    logic [CHANNELS*BYTE_W-1:0] pix_data;
    logic                       busy;
    logic                       frame_done;
    logic [CHANNELS-1:0]        overflow;

    modport master (
        output gpio, gpio_en, start, frame_len, pix_ready,
        input  pix_valid, pix_data, busy, frame_done, overflow
    );

    modport slave (
        input  gpio, gpio_en, start, frame_len, pix_ready,
        output pix_valid, pix_data, busy, frame_done, overflow
    );
endinterface

// File: rtl/gpio_pixel_packer.sv
// Re-interleaves per-channel GPIO words into whole pixels.
// Each colour channel has its own small FIFO filled by gpio_en[c]. A pixel is
// formed from the same byte lane of every FIFO head; after the last lane (or
// the last pixel of the frame) all heads pop together.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : gpio_pixel_packer_if slave (GPIO input, control, pixel stream, status)
module gpio_pixel_packer #(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned BYTE_W   = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CNT_W    = 16
) (
    input logic                clk,
    input logic                rst,
    gpio_pixel_packer_if.slave bus
);
    localparam int unsigned LANES = WORD_W / BYTE_W;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LastLane = LW'(LANES - 1);

    typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

    state_e state_q, state_d;

    // FIFO storage and pointers; pointers carry one extra wrap bit.
    logic [WORD_W-1:0] mem_q    [CHANNELS][DEPTH];
    logic [AW:0]       wr_ptr_q [CHANNELS];
    logic [AW:0]       wr_ptr_d [CHANNELS];
    logic [AW:0]       rd_ptr_q [CHANNELS];
    logic [AW:0]       rd_ptr_d [CHANNELS];

    logic [CHANNELS-1:0] empty;
    logic [CHANNELS-1:0] full;
    logic [CHANNELS-1:0] push;
    logic [CHANNELS-1:0] drop;

    logic [LW-1:0]       lane_q, lane_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [CNT_W-1:0]    cnt_inc;
    logic [CHANNELS-1:0] ovf_q, ovf_d;

    logic                       pix_valid;
    logic [CHANNELS*BYTE_W-1:0] pix_data;
    logic                       busy;
    logic                       frame_done;
    logic                       xfer;
    logic                       last_pix;
    logic                       pop;
    logic                       arm;

    // ------------------------------------------------------------------
    // FIFO status and write acceptance
    // ------------------------------------------------------------------
    always_comb begin
        empty = '0;
        full  = '0;
        push  = '0;
        drop  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            empty[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
            full[c]  = (wr_ptr_q[c][AW] != rd_ptr_q[c][AW]) &&
                       (wr_ptr_q[c][AW-1:0] == rd_ptr_q[c][AW-1:0]);
            // A pop in the same cycle frees the slot the push needs.
            push[c]  = bus.gpio_en[c] && (!full[c] || pop);
            drop[c]  = bus.gpio_en[c] && full[c] && !pop;
        end
    end

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign cnt_inc  = cnt_q + 1'b1;
    assign xfer     = pix_valid && bus.pix_ready;
    assign last_pix = (cnt_inc == len_q);
    // Final pixel pops even mid-word, discarding the unused lanes.
    assign pop      = xfer && ((lane_q == LastLane) || last_pix);
    assign arm      = (state_q == StIdle) && bus.start;

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            wr_ptr_d[c] = push[c] ? wr_ptr_q[c] + (AW+1)'(1) : wr_ptr_q[c];
            rd_ptr_d[c] = pop     ? rd_ptr_q[c] + (AW+1)'(1) : rd_ptr_q[c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                for (int d = 0; d < DEPTH; d++) begin
                    mem_q[c][d] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                if (push[c]) begin
                    mem_q[c][wr_ptr_q[c][AW-1:0]] <= bus.gpio;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Lane, counter, frame length and overflow
    // ------------------------------------------------------------------
    always_comb begin
        lane_d = lane_q;
        cnt_d  = cnt_q;
        len_d  = len_q;
        ovf_d  = ovf_q;
        if (arm) begin
            len_d  = bus.frame_len;
            cnt_d  = '0;
            lane_d = '0;
            ovf_d  = '0;
        end else if (xfer) begin
            cnt_d  = cnt_inc;
            lane_d = pop ? '0 : lane_q + 1'b1;
        end
        // A drop in the arming cycle still counts against the new frame.
        ovf_d = ovf_d | drop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
            ovf_q  <= '0;
        end else begin
            lane_q <= lane_d;
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            ovf_q  <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = (bus.frame_len == '0) ? StDone : StStream;
                end
            end
            StStream: begin
                if (xfer && last_pix) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy       = (state_q != StIdle);
        frame_done = (state_q == StDone);
        pix_valid  = (state_q == StStream) && (empty == '0);
        pix_data   = '0;
        if (pix_valid) begin
            for (int c = 0; c < CHANNELS; c++) begin
                pix_data[c*BYTE_W +: BYTE_W] =
                    mem_q[c][rd_ptr_q[c][AW-1:0]][int'(lane_q)*BYTE_W +: BYTE_W];
            end
        end
    end

    assign bus.pix_valid  = pix_valid;
    assign bus.pix_data   = pix_data;
    assign bus.busy       = busy;
    assign bus.frame_done = frame_done;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_gpio_pixel_packer.sv
module tb_gpio_pixel_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    gpio_pixel_packer_if bus ();

    gpio_pixel_packer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0]       r;
        logic [31:0]       g;
        logic [31:0]       b;
        logic [15:0]       len;
        logic [3:0][23:0]  pix;
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [2:0] mask, input logic [31:0] word);
        bus.gpio    = word;
        bus.gpio_en = mask;
        tick();
        bus.gpio_en = '0;
    endtask

    task automatic start_frame(input logic [15:0] len);
        bus.start     = 1'b1;
        bus.frame_len = len;
        tick();
        bus.start     = 1'b0;
    endtask

    // Waits (bounded) for a pixel, checks it, and accepts it.
    task automatic take(input string name, input logic [23:0] exp);
        int n = 0;
        bus.pix_ready = 1'b1;
        while (!bus.pix_valid && n < 20) begin
            tick();
            n++;
        end
        check({name, " valid"}, 64'(bus.pix_valid), 64'd1);
        check({name, " data"}, 64'(bus.pix_data), 64'(exp));
        tick();
    endtask

    task automatic expect_done(input string name);
        check({name, " frame_done"}, 64'(bus.frame_done), 64'd1);
        check({name, " busy in done"}, 64'(bus.busy), 64'd1);
        check({name, " valid in done"}, 64'(bus.pix_valid), 64'd0);
        tick();
        check({name, " frame_done low"}, 64'(bus.frame_done), 64'd0);
        check({name, " busy low"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        logic [7:0] x;

        vecs[0].r = 32'h44332211; vecs[0].g = 32'h88776655; vecs[0].b = 32'hCCBBAA99;
        vecs[0].len = 16'd4;
        vecs[0].pix[0] = 24'h995511; vecs[0].pix[1] = 24'hAA6622;
        vecs[0].pix[2] = 24'hBB7733; vecs[0].pix[3] = 24'hCC8844;
        vecs[1].r = 32'h03020100; vecs[1].g = 32'h13121110; vecs[1].b = 32'h23222120;
        vecs[1].len = 16'd2;
        vecs[1].pix[0] = 24'h201000; vecs[1].pix[1] = 24'h211101;
        vecs[1].pix[2] = 24'h0;      vecs[1].pix[3] = 24'h0;
        vecs[2].r = 32'hDEADBEEF; vecs[2].g = 32'h01234567; vecs[2].b = 32'h89ABCDEF;
        vecs[2].len = 16'd3;
        vecs[2].pix[0] = 24'hEF67EF; vecs[2].pix[1] = 24'hCD45BE;
        vecs[2].pix[2] = 24'hAB23AD; vecs[2].pix[3] = 24'h0;
        vecs[3].r = 32'hFFFFFFFF; vecs[3].g = 32'h00000000; vecs[3].b = 32'h80808080;
        vecs[3].len = 16'd1;
        vecs[3].pix[0] = 24'h8000FF; vecs[3].pix[1] = 24'h0;
        vecs[3].pix[2] = 24'h0;      vecs[3].pix[3] = 24'h0;

        bus.gpio      = '0;
        bus.gpio_en   = '0;
        bus.start     = 1'b0;
        bus.frame_len = '0;
        bus.pix_ready = 1'b1;

        // Reset state
        #2;
        check("reset pix_valid", 64'(bus.pix_valid), 64'd0);
        check("reset pix_data", 64'(bus.pix_data), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset frame_done", 64'(bus.frame_done), 64'd0);
        check("reset overflow", 64'(bus.overflow), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Single-word frames of various lengths; each frame must leave the FIFOs empty.
        for (int v = 0; v < 4; v++) begin
            push(3'b001, vecs[v].r);
            push(3'b010, vecs[v].g);
            push(3'b100, vecs[v].b);
            start_frame(vecs[v].len);
            check($sformatf("v%0d busy", v), 64'(bus.busy), 64'd1);
            for (int k = 0; k < int'(vecs[v].len); k++) begin
                take($sformatf("v%0d p%0d", v, k), vecs[v].pix[k]);
            end
            expect_done($sformatf("v%0d", v));
        end

        // Backpressure holds the first pixel.
        bus.pix_ready = 1'b0;
        push(3'b001, 32'h44332211);
        push(3'b010, 32'h88776655);
        push(3'b100, 32'hCCBBAA99);
        start_frame(16'd4);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stall valid %0d", k), 64'(bus.pix_valid), 64'd1);
            check($sformatf("stall data %0d", k), 64'(bus.pix_data), 64'h995511);
            tick();
        end
        take("stall p0", 24'h995511);
        take("stall p1", 24'hAA6622);
        take("stall p2", 24'hBB7733);
        take("stall p3", 24'hCC8844);
        expect_done("stall");

        // Overflow on the fifth R word; start clears the flag.
        for (int i = 1; i <= 5; i++) begin
            push(3'b001, 32'hA0A0A0A0 + 32'(i) * 32'h01010101);
            if (i == 4) check("ovf before full push", 64'(bus.overflow), 64'd0);
        end
        check("ovf set", 64'(bus.overflow), 64'b001);
        for (int i = 1; i <= 4; i++) begin
            push(3'b010, 32'hB0B0B0B0 + 32'(i) * 32'h01010101);
            push(3'b100, 32'hC0C0C0C0 + 32'(i) * 32'h01010101);
        end
        check("ovf sticky", 64'(bus.overflow), 64'b001);
        start_frame(16'd16);
        check("ovf cleared by start", 64'(bus.overflow), 64'd0);
        for (int k = 0; k < 16; k++) begin
            x = 8'(k / 4 + 1);
            take($sformatf("ovf p%0d", k), {8'hC0 + x, 8'hB0 + x, 8'hA0 + x});
        end
        expect_done("ovf");

        // Missing channel keeps pix_valid low; the dropped R word must be gone.
        start_frame(16'd1);
        push(3'b010, 32'h33333333);
        push(3'b100, 32'h44444444);
        tick();
        check("no R valid low", 64'(bus.pix_valid), 64'd0);
        push(3'b001, 32'h22222222);
        check("R arrives valid", 64'(bus.pix_valid), 64'd1);
        take("late R p0", 24'h443322);
        expect_done("late R");

        // Two words per channel, frame ends mid-word; leftover lanes discarded.
        push(3'b001, 32'h03020100); push(3'b010, 32'h13121110); push(3'b100, 32'h23222120);
        push(3'b001, 32'h07060504); push(3'b010, 32'h17161514); push(3'b100, 32'h27262524);
        start_frame(16'd6);
        for (int k = 0; k < 6; k++) begin
            x = 8'(k);
            take($sformatf("two p%0d", k), {8'h20 + x, 8'h10 + x, x});
        end
        expect_done("two");
        start_frame(16'd1);
        push(3'b111, 32'h09090909);
        take("after two p0", 24'h090909);
        expect_done("after two");

        // Push to a full FIFO on the same edge as a pop is accepted.
        for (int i = 1; i <= 4; i++) push(3'b111, 32'h11111111 * 32'(i));
        start_frame(16'd8);
        for (int k = 0; k < 8; k++) begin
            x = 8'h11 * 8'(k / 4 + 1);
            if (k == 3) begin
                bus.gpio    = 32'h55555555;
                bus.gpio_en = 3'b111;
            end
            take($sformatf("pushpop p%0d", k), {x, x, x});
            bus.gpio_en = '0;
        end
        expect_done("pushpop");
        check("pushpop no ovf", 64'(bus.overflow), 64'd0);
        start_frame(16'd12);
        for (int k = 0; k < 12; k++) begin
            x = 8'h11 * 8'(k / 4 + 3);
            take($sformatf("drain p%0d", k), {x, x, x});
        end
        expect_done("drain");

        // Zero-length frame goes straight to DONE.
        start_frame(16'd0);
        expect_done("zero len");

        // Asynchronous reset mid-frame.
        push(3'b001, 32'h44332211);
        push(3'b010, 32'h88776655);
        push(3'b100, 32'hCCBBAA99);
        push(3'b010, 32'hEEEEEEEE);
        start_frame(16'd4);
        take("pre-rst p0", 24'h995511);
        take("pre-rst p1", 24'hAA6622);
        rst = 1'b1;
        #1;
        check("rst pix_valid", 64'(bus.pix_valid), 64'd0);
        check("rst pix_data", 64'(bus.pix_data), 64'd0);
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst frame_done", 64'(bus.frame_done), 64'd0);
        check("rst overflow", 64'(bus.overflow), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        push(3'b001, 32'h03020100);
        push(3'b010, 32'h13121110);
        push(3'b100, 32'h23222120);
        start_frame(16'd4);
        for (int k = 0; k < 4; k++) begin
            x = 8'(k);
            take($sformatf("post-rst p%0d", k), {8'h20 + x, 8'h10 + x, x});
        end
        expect_done("post-rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/gpio_pixel_packer.md
Name: gpio_pixel_packer

Overview:
Collects the per-channel 32-bit GPIO words the processor emits (one write-enable per colour channel, four packed 8-bit samples per word) and re-interleaves them into whole pixels, one pixel per beat, over a valid/ready stream. It sits between the processor GPIO output and the frame sink (display/capture) and is generalised in channel count, word width, sample width and buffer depth. It adds a programmable frame length, per-channel buffering with backpressure, and sticky overflow flags.

Parameters:
CHANNELS, 3, number of colour channels (ch0 = R, ch1 = G, ch2 = B by default).
WORD_W, 32, GPIO word width; must be a multiple of BYTE_W.
BYTE_W, 8, sample width; LANES = WORD_W/BYTE_W samples per word.
DEPTH, 4, words per channel FIFO; power of two, at least 2.
CNT_W, 16, width of frame length and pixel counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
gpio  in  WORD_W  processor GPIO data word.
gpio_en  in  CHANNELS  per-channel write enable; bit c pushes gpio into FIFO c.
start  in  1  one-cycle pulse that arms a frame; ignored unless in IDLE.
frame_len  in  CNT_W  pixels in the frame, sampled on start.
pix_valid  out  1  pixel available.
pix_ready  in  1  sink accepts pixel.
pix_data  out  CHANNELS*BYTE_W  pixel; channel c occupies bits [c*BYTE_W +: BYTE_W].
busy  out  1  high in STREAM and DONE.
frame_done  out  1  one-cycle pulse at end of frame.
overflow  out  CHANNELS  sticky per-channel drop flag.

Behaviour:
- Reset (asynchronous, any time, including mid-frame): state IDLE, FIFOs empty and storage zeroed, lane = 0, pixel counter = 0. Outputs: pix_valid 0, pix_data 0, busy 0, frame_done 0, overflow 0.
- FIFO write side: writes are accepted in every state.
  - Each asserted gpio_en bit pushes gpio into that channel's FIFO.
  - If several bits are asserted, the same word goes to each selected FIFO.
  - A push to a full FIFO drops the word and sets overflow[c].
  - A push to a full FIFO in the same cycle as a pop of that FIFO is accepted and does not set overflow.
- Lane/pixel formation:
  - pix_valid = (state == STREAM) AND every channel FIFO is non-empty.
  - pix_data is combinational from the FIFO heads: sample lane L of each head word, where lane 0 = bits [BYTE_W-1:0].
  - pix_data is 0 whenever pix_valid is 0.
  - A word pushed at edge N can produce pix_valid from the cycle after edge N.
- Handshake:
  - A transfer occurs on an edge where pix_valid AND pix_ready are both high.
  - On a transfer: the pixel counter increments. If lane == LANES-1 or this was the last pixel of the frame, all FIFOs pop together and lane resets to 0; otherwise lane increments.
  - While pix_valid is high and pix_ready is low, pix_data is held stable, because pushes only touch FIFO tails.
  - pix_valid never drops without a transfer except on reset.
- FSM:
  - IDLE: on start, latch frame_len, clear the counter, lane and overflow. Go to STREAM if frame_len is non-zero, else go to DONE.
  - STREAM: on the transfer that brings the counter to the latched frame_len, go to DONE. Unconsumed lanes of the final word are discarded by the pop.
  - DONE: frame_done = 1 for exactly this one cycle, then go to IDLE.
  - start outside IDLE is ignored.
- Counter: unsigned CNT_W bits. The maximum frame is 2^CNT_W - 1 pixels, so the counter never wraps within a frame.

Test Plan:
1. Push R=0x44332211, G=0x88776655, B=0xCCBBAA99; then start with frame_len=4 and pix_ready=1 -> pix_data is 0x995511, 0xAA6622, 0xBB7733, 0xCC8844 on 4 consecutive cycles; frame_done pulses on the next cycle; busy drops after it; all FIFOs are empty.
2. Same stimulus as scenario 1, with pix_ready low for 3 cycles after the first pix_valid -> pix_data is held at 0x995511 for those 3 cycles and the counter stays 0; the stream then completes as in scenario 1.
3. Push 5 words to R only, with no frame running -> overflow = 3'b001 and the 5th word is absent from the FIFO. Then push 4 G and 4 B words and start with frame_len=16 -> overflow clears to 0 and 16 pixels are streamed using R words 1-4.
4. Push two words per channel, then start with frame_len=6 -> 6 pixels are streamed (lanes 0-3 of word 1, lanes 0-1 of word 2); frame_done pulses; all FIFOs are empty afterwards.
5. Start with frame_len=2, then push R and G only -> pix_valid stays 0. Push B -> pix_valid rises on the following cycle. Separately, start with frame_len=0 -> frame_done pulses on the cycle after start.
6. Assert rst after 2 transfers of a 4-pixel frame -> all outputs are 0 immediately, state is IDLE, FIFOs are empty. A new start with fresh data then streams correctly from lane 0.
